// File: rtl/cpu_run_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : cpu_run_ctrl
//  Purpose  : Run/step/breakpoint sequencer driving the PIC10 core clock enable.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PC_W            = 9,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             step_key_n,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             instr_done,
    input  logic             cnt_clr,
    output logic             cpu_ce,
    output logic [1:0]       state_o,
    output logic             break_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [1:0] c_HALT  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_STEP  = 2'b10;
    localparam logic [1:0] c_BREAK = 2'b11;

    localparam int                c_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    logic              r_run_meta;
    logic              r_run_s;
    logic              r_key_meta;
    logic              r_key_s;
    logic              r_key_db;
    logic              r_key_db_d;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_break_hit;
    logic [CNT_W-1:0]  r_instr_count;
    logic              w_step_req;
    logic              w_done;
    logic              w_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
        end else begin
            r_run_meta <= run_sw;
            r_run_s    <= r_run_meta;
            r_key_meta <= step_key_n;
            r_key_s    <= r_key_meta;
        end
    end

    // Counter restarts whenever the synced key agrees with the accepted level,
    // so any bounce back restarts the stability window from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt   <= '0;
            r_key_db   <= 1'b1;
            r_key_db_d <= 1'b1;
        end else begin
            r_key_db_d <= r_key_db;
            if (r_key_s == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_key_db <= r_key_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end
        end
    end

    assign w_step_req = r_key_db_d & ~r_key_db;
    assign w_done     = instr_done & cpu_ce;
    assign w_match    = bp_en & (pc == bp_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_HALT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_HALT: begin
                if (r_run_s) begin
                    w_state_next = c_RUN;
                end else if (w_step_req) begin
                    w_state_next = c_STEP;
                end
            end
            c_RUN: begin
                if (w_done && w_match) begin
                    w_state_next = c_BREAK;
                end else if (w_done && !r_run_s) begin
                    w_state_next = c_HALT;
                end
            end
            c_STEP: begin
                if (w_done) begin
                    w_state_next = c_HALT;
                end
            end
            c_BREAK: begin
                if (w_step_req) begin
                    w_state_next = c_STEP;
                end else if (!r_run_s) begin
                    w_state_next = c_HALT;
                end
            end
            default: w_state_next = c_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_break_hit <= 1'b0;
        end else begin
            r_break_hit <= (w_state_next == c_BREAK) && (r_state != c_BREAK);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_count <= '0;
        end else if (cnt_clr) begin
            r_instr_count <= '0;
        end else if (w_done) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    // Decoded straight from the state flops so reset removes the enable immediately.
    assign cpu_ce      = (r_state == c_RUN) || (r_state == c_STEP);
    assign state_o     = r_state;
    assign break_hit   = r_break_hit;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cpu_run_ctrl
//  Purpose  : Self-checking bench for cpu_run_ctrl with a simple core model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int PC_W  = 9;
    localparam int CNT_W = 16;
    localparam logic [1:0] c_HALT  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_STEP  = 2'b10;
    localparam logic [1:0] c_BREAK = 2'b11;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             run_sw     = 1'b0;
    logic             step_key_n = 1'b1;
    logic             bp_en      = 1'b0;
    logic [PC_W-1:0]  bp_addr    = '0;
    logic             cnt_clr    = 1'b0;
    logic             fast       = 1'b0;
    logic             ext_done   = 1'b0;
    logic [PC_W-1:0]  pc;
    logic             instr_done;
    logic             cpu_ce;
    logic [1:0]       state_o;
    logic             break_hit;
    logic [CNT_W-1:0] instr_count;

    logic [1:0]       r_phase;
    logic [PC_W-1:0]  r_core_ret;

    typedef struct {
        logic [1:0]       st;
        logic [CNT_W-1:0] cnt;
    } sb_t;
    sb_t sb_q[$];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ce_total = 0;
    logic [1:0] prev_state = 2'b00;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .PC_W            (PC_W),
        .CNT_W           (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .run_sw      (run_sw),
        .step_key_n  (step_key_n),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .instr_done  (instr_done),
        .cnt_clr     (cnt_clr),
        .cpu_ce      (cpu_ce),
        .state_o     (state_o),
        .break_hit   (break_hit),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Core model: one instruction per 4 enabled cycles (every enabled cycle in fast mode).
    assign instr_done = (cpu_ce && (fast || (r_phase == 2'd3))) || ext_done;
    assign pc         = r_core_ret + {{(PC_W-1){1'b0}}, instr_done};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase    <= 2'd0;
            r_core_ret <= '0;
        end else if (cpu_ce) begin
            r_phase <= r_phase + 2'd1;
            if (instr_done) begin
                r_core_ret <= r_core_ret + 1'b1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [1:0] st, input logic [CNT_W-1:0] c);
        sb_t e;
        e.st  = st;
        e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] exp, input int budget, input string tag);
        int i;
        i = 0;
        while ((state_o !== exp) && (i < budget)) begin
            @(negedge clk);
            i++;
        end
        check_eq(tag, 32'(state_o), 32'(exp));
    endtask

    // Scoreboard: every state change must match the next queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_state <= c_HALT;
        end else begin
            if (cpu_ce) ce_total <= ce_total + 1;
            if (state_o != prev_state) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_state", 32'(state_o), 32'(prev_state));
                end else begin
                    check_eq("sb_state", 32'(state_o), 32'(sb_q[0].st));
                    check_eq("sb_count", 32'(instr_count), 32'(sb_q[0].cnt));
                    void'(sb_q.pop_front());
                end
            end
            prev_state <= state_o;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               ce_snap;
        int               i;
        logic [CNT_W-1:0] exp_cnt;
        logic [CNT_W-1:0] last_cnt;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(state_o), 32'(c_HALT));
        check_eq("rst_ce", 32'(cpu_ce), 32'd0);
        check_eq("rst_break_hit", 32'(break_hit), 32'd0);
        check_eq("rst_count", 32'(instr_count), 32'd0);
        bp_en   = 1'b1;
        bp_addr = 9'h005;
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        check_eq("halt_after_rst", 32'(state_o), 32'(c_HALT));

        // Free run, count, breakpoint at pc=5
        sb_push(c_RUN, 16'd0);
        sb_push(c_BREAK, 16'd5);
        run_sw = 1'b1;
        tick(2);
        check_eq("run_sync_latency", 32'(state_o), 32'(c_HALT));
        tick(1);
        check_eq("run_entry", 32'(state_o), 32'(c_RUN));
        check_eq("run_ce", 32'(cpu_ce), 32'd1);
        tick(3);
        check_eq("cnt_before_first", 32'(instr_count), 32'd0);
        check_eq("first_done", 32'(instr_done), 32'd1);
        tick(1);
        check_eq("cnt_1", 32'(instr_count), 32'd1);
        tick(4);
        check_eq("cnt_2", 32'(instr_count), 32'd2);
        tick(4);
        check_eq("cnt_3", 32'(instr_count), 32'd3);
        wait_state(c_BREAK, 20, "bp_break");
        check_eq("break_hit_set", 32'(break_hit), 32'd1);
        check_eq("break_ce", 32'(cpu_ce), 32'd0);
        check_eq("pc_at_break", 32'(pc), 32'd5);
        tick(1);
        check_eq("break_hit_pulse", 32'(break_hit), 32'd0);
        check_eq("break_stays", 32'(state_o), 32'(c_BREAK));

        // Single step out of BREAK
        sb_push(c_STEP, 16'd5);
        sb_push(c_HALT, 16'd6);
        step_key_n = 1'b0;
        wait_state(c_STEP, 20, "step_from_break");
        run_sw = 1'b0;
        wait_state(c_HALT, 20, "step_done");
        check_eq("pc_after_step", 32'(pc), 32'd6);
        step_key_n = 1'b1;
        tick(12);
        check_eq("halt_hold", 32'(state_o), 32'(c_HALT));

        // run_sw drop mid-instruction waits for the boundary
        bp_en = 1'b0;
        sb_push(c_RUN, 16'd6);
        sb_push(c_HALT, 16'd7);
        run_sw = 1'b1;
        tick(3);
        check_eq("run_entry_2", 32'(state_o), 32'(c_RUN));
        tick(1);
        run_sw = 1'b0;
        tick(2);
        check_eq("ce_held_mid_instr", 32'(cpu_ce), 32'd1);
        tick(1);
        check_eq("halt_at_boundary", 32'(state_o), 32'(c_HALT));
        check_eq("count_after_drop", 32'(instr_count), 32'd7);

        // Breakpoint and run drop on the same boundary
        bp_addr = 9'h009;
        bp_en   = 1'b1;
        sb_push(c_RUN, 16'd7);
        sb_push(c_BREAK, 16'd9);
        sb_push(c_HALT, 16'd9);
        run_sw = 1'b1;
        tick(3);
        check_eq("run_entry_3", 32'(state_o), 32'(c_RUN));
        tick(5);
        run_sw = 1'b0;
        wait_state(c_BREAK, 10, "bp_over_drop");
        check_eq("break_hit_2", 32'(break_hit), 32'd1);
        wait_state(c_HALT, 5, "break_to_halt");

        // Bounce rejected, held key gives one step
        bp_en = 1'b0;
        tick(2);
        step_key_n = 1'b0;
        tick(3);
        step_key_n = 1'b1;
        tick(15);
        check_eq("bounce_ignored", 32'(state_o), 32'(c_HALT));
        check_eq("bounce_count", 32'(instr_count), 32'd9);
        ce_snap = ce_total;
        sb_push(c_STEP, 16'd9);
        sb_push(c_HALT, 16'd10);
        step_key_n = 1'b0;
        tick(30);
        step_key_n = 1'b1;
        tick(10);
        check_eq("single_step_halt", 32'(state_o), 32'(c_HALT));
        check_eq("single_step_count", 32'(instr_count), 32'd10);
        check_eq("step_ce_cycles", 32'(ce_total - ce_snap), 32'd4);

        // instr_done with cpu_ce=0 is ignored
        ext_done = 1'b1;
        tick(3);
        ext_done = 1'b0;
        tick(1);
        check_eq("done_ignored_halt", 32'(instr_count), 32'd10);

        // Wrap of the retired-instruction counter
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check_eq("cnt_clr_halt", 32'(instr_count), 32'd0);
        fast = 1'b1;
        sb_push(c_RUN, 16'd0);
        run_sw = 1'b1;
        i = 0;
        while ((instr_count != 16'hFFFD) && (i < 70000)) begin
            @(negedge clk);
            i++;
        end
        check_eq("preset_reach", 32'(instr_count), 32'hFFFD);
        fast    = 1'b0;
        exp_cnt = 16'hFFFD;
        for (int k = 0; k < 3; k++) begin
            exp_cnt  = exp_cnt + 16'd1;
            last_cnt = instr_count;
            i = 0;
            while ((instr_count == last_cnt) && (i < 10)) begin
                @(negedge clk);
                i++;
            end
            check_eq("wrap_seq", 32'(instr_count), 32'(exp_cnt));
        end

        // cnt_clr wins over a simultaneous done
        i = 0;
        @(negedge clk);
        while ((instr_done !== 1'b1) && (i < 10)) begin
            @(negedge clk);
            i++;
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check_eq("clr_over_done", 32'(instr_count), 32'd0);

        // Asynchronous reset mid-RUN
        tick(5);
        @(posedge clk);
        #3;
        check_eq("run_before_rst", 32'(cpu_ce), 32'd1);
        rst    = 1'b1;
        run_sw = 1'b0;
        #1;
        check_eq("ce_async_drop", 32'(cpu_ce), 32'd0);
        check_eq("rst_state_2", 32'(state_o), 32'(c_HALT));
        check_eq("rst_break_hit_2", 32'(break_hit), 32'd0);
        check_eq("rst_count_2", 32'(instr_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(6);
        check_eq("halt_after_release", 32'(state_o), 32'(c_HALT));
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
